branch_pc_ctrl: RTL and testbench

Program-counter and redirect controller that sits directly downstream of the branch comparator in the execute stage. It takes the comparator's taken/not-taken result and the jump and branch decode from EX, and computes the target address. It owns the fetch PC register and produces a one-cycle pipeline flush on every redirect. It also halts fetch on a misaligned target and counts taken redirects for performance monitoring.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/target_gen.sv | 32 +++
 rtl/branch_pc_ctrl.sv | 140 ++++++++++++++
 tb/tb_branch_pc_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the execute-stage PC/redirect controller.
//   XLEN    : datapath width
//   PC_STEP : sequential fetch increment
//   state_e : redirect controller FSM states
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_e;

  // A redirect target must be word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/target_gen.sv
// Combinational redirect target generator.
// Ports:
//   is_jalr  : select JALR addressing (rs1 + imm, LSB cleared)
//   ex_pc    : PC of the EX instruction (JAL / branch base)
//   imm      : sign-extended immediate
//   rs1      : JALR base register value
//   target   : computed redirect address (wraps mod 2^32)
//   misalign : target is not word aligned
module target_gen
  import cpu_pkg::*;
(
  input  logic            is_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] base;

  always_comb begin
    base   = is_jalr ? rs1 : ex_pc;
    target = base + imm;
    // JALR discards bit 0 of the sum; JAL/branch keep it so odd offsets still flag.
    if (is_jalr) begin
      target[0] = 1'b0;
    end
    misalign = is_misaligned(target);
  end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Fetch PC owner and redirect controller placed after the branch comparator in EX.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   stall        : pipeline freeze, holds PC and EX request while in RUN
//   ex_valid     : EX instruction valid
//   is_branch    : conditional branch, br_taken is the comparator result
//   is_jal       : JAL in EX
//   is_jalr      : JALR in EX (highest priority)
//   ex_pc, imm   : EX PC and sign-extended immediate
//   rs1          : JALR base
//   pc           : current fetch PC
//   fetch_valid  : pc is a valid fetch request
//   flush        : kill IF/ID (one cycle per redirect, held while halted)
//   link_addr    : ex_pc + 4 for rd writeback
//   misalign     : sticky misaligned-target flag
//   taken_cnt    : saturating count of accepted redirects
module branch_pc_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             is_branch,
  input  logic             br_taken,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  output logic [XLEN-1:0]  pc,
  output logic             fetch_valid,
  output logic             flush,
  output logic [XLEN-1:0]  link_addr,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              flush_q, flush_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

  logic              redirect_req;
  logic [XLEN-1:0]   target;
  logic              target_misalign;

  // JAL and branch share the ex_pc-relative path, so only JALR needs to steer the adder.
  target_gen u_target_gen (
    .is_jalr  (is_jalr),
    .ex_pc    (ex_pc),
    .imm      (imm),
    .rs1      (rs1),
    .target   (target),
    .misalign (target_misalign)
  );

  assign redirect_req = ex_valid & (is_jalr | is_jal | (is_branch & br_taken));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = flush_q;
    misalign_d    = misalign_q;
    taken_cnt_d   = taken_cnt_q;

    unique case (state_q)
      RUN: begin
        if (!stall && redirect_req) begin
          fetch_valid_d = 1'b0;
          flush_d       = 1'b1;
          if (target_misalign) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            pc_d    = target;
            state_d = FLUSH;
            if (taken_cnt_q != {CNT_W{1'b1}}) begin
              taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
          end
        end else begin
          fetch_valid_d = 1'b1;
          flush_d       = 1'b0;
          // The first valid cycle after reset fetches RESET_PC itself; advance only
          // once the current pc has actually been presented as a valid fetch.
          if (!stall && fetch_valid_q) begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      FLUSH: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
        flush_d       = 1'b0;
      end
      HALT: begin
        fetch_valid_d = 1'b0;
        flush_d       = 1'b1;
      end
      default: begin
        state_d       = RUN;
        fetch_valid_d = 1'b0;
        flush_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
  assign misalign    = misalign_q;
  assign taken_cnt   = taken_cnt_q;
  assign link_addr   = ex_pc + PC_STEP;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Self-checking bench for branch_pc_ctrl: table-driven vectors with a scoreboard queue.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_branch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, ex_valid, is_branch, br_taken, is_jal, is_jalr;
  logic [31:0] ex_pc, imm, rs1;
  logic [31:0] pc, link_addr, pc2, link_addr2;
  logic        fetch_valid, flush, misalign, fetch_valid2, flush2, misalign2;
  logic [15:0] taken_cnt;
  logic [1:0]  taken_cnt2;

  always #5 clk = ~clk;

  branch_pc_ctrl #(.RESET_PC(32'h100), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .is_branch(is_branch),
    .br_taken(br_taken), .is_jal(is_jal), .is_jalr(is_jalr), .ex_pc(ex_pc), .imm(imm),
    .rs1(rs1), .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .link_addr(link_addr),
    .misalign(misalign), .taken_cnt(taken_cnt)
  );

  branch_pc_ctrl #(.RESET_PC(32'h100), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .is_branch(is_branch),
    .br_taken(br_taken), .is_jal(is_jal), .is_jalr(is_jalr), .ex_pc(ex_pc), .imm(imm),
    .rs1(rs1), .pc(pc2), .fetch_valid(fetch_valid2), .flush(flush2),
    .link_addr(link_addr2), .misalign(misalign2), .taken_cnt(taken_cnt2)
  );

  typedef struct {
    logic        rst, stall, vld, br, tk, jal, jalr;
    logic [31:0] ex_pc, imm, rs1;
    logic [31:0] e_pc;
    logic        e_fv, e_fl, e_mis;
    logic [15:0] e_cnt;
    logic [1:0]  e_cnt2;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        fv, fl, mis;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ctl = {rst, stall, vld, br, tk, jal, jalr}; ef = {fetch_valid, flush, misalign}
  function automatic vec_t vec(input int unsigned ctl, input int unsigned xpc,
                               input int unsigned im, input int unsigned r1,
                               input int unsigned epc, input int unsigned ef,
                               input int unsigned ecnt);
    vec_t v;
    v.rst    = ctl[6];
    v.stall  = ctl[5];
    v.vld    = ctl[4];
    v.br     = ctl[3];
    v.tk     = ctl[2];
    v.jal    = ctl[1];
    v.jalr   = ctl[0];
    v.ex_pc  = xpc;
    v.imm    = im;
    v.rs1    = r1;
    v.e_pc   = epc;
    v.e_fv   = ef[2];
    v.e_fl   = ef[1];
    v.e_mis  = ef[0];
    v.e_cnt  = ecnt[15:0];
    v.e_cnt2 = (ecnt > 3) ? 2'd3 : ecnt[1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    rst       = v.rst;
    stall     = v.stall;
    ex_valid  = v.vld;
    is_branch = v.br;
    br_taken  = v.tk;
    is_jal    = v.jal;
    is_jalr   = v.jalr;
    ex_pc     = v.ex_pc;
    imm       = v.imm;
    rs1       = v.rs1;
    #1;
    chk("link_addr", link_addr, v.ex_pc + 32'd4);
    sb.push_back('{pc: v.e_pc, fv: v.e_fv, fl: v.e_fl, mis: v.e_mis, cnt: v.e_cnt,
                   cnt2: v.e_cnt2});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc", pc, e.pc);
    chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.fv});
    chk("flush", {31'b0, flush}, {31'b0, e.fl});
    chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
    chk("taken_cnt", {16'b0, taken_cnt}, {16'b0, e.cnt});
    chk("taken_cnt_w2", {30'b0, taken_cnt2}, {30'b0, e.cnt2});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; is_branch = 1'b0; br_taken = 1'b0;
    is_jal = 1'b0; is_jalr = 1'b0; ex_pc = '0; imm = '0; rs1 = '0;
    @(posedge clk);
    #1;

    // Reset release and sequential fetch
    vecs.push_back(vec('b1000000, 0, 0, 0, 'h100, 'b000, 0));
    vecs.push_back(vec('b0000000, 0, 0, 0, 'h100, 'b100, 0));
    vecs.push_back(vec('b0000000, 0, 0, 0, 'h104, 'b100, 0));
    vecs.push_back(vec('b0000000, 0, 0, 0, 'h108, 'b100, 0));
    vecs.push_back(vec('b0000000, 0, 0, 0, 'h10C, 'b100, 0));
    // Taken branch backwards; wrong-path JAL during FLUSH is ignored
    vecs.push_back(vec('b0011100, 'h200, 'hFFFF_FFF8, 0, 'h1F8, 'b010, 1));
    vecs.push_back(vec('b0010010, 'h300, 'h40, 0, 'h1F8, 'b100, 1));
    vecs.push_back(vec('b0000000, 0, 0, 0, 'h1FC, 'b100, 1));
    // Not-taken branch, then JALR winning priority over JAL/branch
    vecs.push_back(vec('b0011000, 'h500, 'h20, 0, 'h200, 'b100, 1));
    vecs.push_back(vec('b0011111, 'h600, 'h10, 'h1001, 'h1010, 'b010, 2));
    vecs.push_back(vec('b0000000, 0, 0, 0, 'h1010, 'b100, 2));
    // Request held under stall for two cycles, then accepted
    vecs.push_back(vec('b0110010, 'h1010, 'h100, 0, 'h1010, 'b100, 2));
    vecs.push_back(vec('b0110010, 'h1010, 'h100, 0, 'h1010, 'b100, 2));
    vecs.push_back(vec('b0010010, 'h1010, 'h100, 0, 'h1110, 'b010, 3));
    vecs.push_back(vec('b0100000, 0, 0, 0, 'h1110, 'b100, 3));
    vecs.push_back(vec('b0000000, 0, 0, 0, 'h1114, 'b100, 3));
    // Misaligned JAL target -> HALT, sticky, only reset exits
    vecs.push_back(vec('b0010010, 'h40, 'h6, 0, 'h1114, 'b011, 3));
    vecs.push_back(vec('b0000000, 0, 0, 0, 'h1114, 'b011, 3));
    vecs.push_back(vec('b0010010, 0, 'h80, 0, 'h1114, 'b011, 3));
    vecs.push_back(vec('b1000000, 0, 0, 0, 'h100, 'b000, 0));
    // Reset in the middle of FLUSH
    vecs.push_back(vec('b0000000, 0, 0, 0, 'h100, 'b100, 0));
    vecs.push_back(vec('b0010010, 'h100, 'h20, 0, 'h120, 'b010, 1));
    vecs.push_back(vec('b1000000, 0, 0, 0, 'h100, 'b000, 0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Counter saturation (narrow instance) and PC wrap
    run_vec(vec('b0000000, 0, 0, 0, 'h100, 'b100, 0));
    for (int k = 0; k < 5; k++) begin
      int unsigned t;
      t = 32'h200 + 32'h10 * k;
      run_vec(vec('b0010010, 'h100, t - 'h100, 0, t, 'b010, k + 1));
      run_vec(vec('b0000000, 0, 0, 0, t, 'b100, k + 1));
    end
    run_vec(vec('b0010010, 0, 'hFFFF_FFFC, 0, 'hFFFF_FFFC, 'b010, 6));
    run_vec(vec('b0000000, 0, 0, 0, 'hFFFF_FFFC, 'b100, 6));
    run_vec(vec('b0000000, 0, 0, 0, 'h0, 'b100, 6));
    // link_addr wrap
    run_vec(vec('b0000000, 'hFFFF_FFFC, 0, 0, 'h4, 'b100, 6));

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
